// File: rtl/mmio_pkg.sv
// Shared constants and I/O decode helper for the mmio_mem block.
// I/O offsets are measured downward from the all-ones word address.
package mmio_pkg;

    localparam int unsigned IO_SIZE = 4;
    localparam int unsigned IO_BITS = $clog2(IO_SIZE);

    localparam logic [IO_BITS-1:0] LED_OFS = IO_BITS'(0);
    localparam logic [IO_BITS-1:0] SW_OFS  = IO_BITS'(1);
    localparam logic [IO_BITS-1:0] CYC_OFS = IO_BITS'(2);
    localparam logic [IO_BITS-1:0] SCR_OFS = IO_BITS'(3);

    typedef enum logic [2:0] {
        SEL_RAM,
        SEL_LED,
        SEL_SW,
        SEL_CYC,
        SEL_SCR
    } io_sel_e;

    // is_io: upper address bits all ones; ofs: inverted low address bits.
    function automatic io_sel_e decode_sel(input logic is_io, input logic [IO_BITS-1:0] ofs);
        io_sel_e sel;
        sel = SEL_RAM;
        if (is_io) begin
            case (ofs)
                LED_OFS: sel = SEL_LED;
                SW_OFS:  sel = SEL_SW;
                CYC_OFS: sel = SEL_CYC;
                SCR_OFS: sel = SEL_SCR;
                default: sel = SEL_RAM;
            endcase
        end
        return sel;
    endfunction

endpackage

// File: rtl/mmio_mem_if.sv
// Read/write bus of the mmio_mem block: independent read and write ports
// with a per-byte write mask and a one-cycle rd_valid strobe.
interface mmio_mem_if #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 32
);
    localparam int unsigned BE_W = DATA_W / 8;

    logic              rd_en;
    logic [ADDR_W-1:0] read_address;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              write_enable;
    logic [ADDR_W-1:0] write_address;
    logic [DATA_W-1:0] write_data;
    logic [BE_W-1:0]   byte_en;

    modport master (
        output rd_en, read_address, write_enable, write_address, write_data, byte_en,
        input  rd_data, rd_valid
    );

    modport slave (
        input  rd_en, read_address, write_enable, write_address, write_data, byte_en,
        output rd_data, rd_valid
    );
endinterface

// File: rtl/mmio_mem_ram.sv
// Byte-enabled, read-first, synchronous-read simple dual-port RAM written
// in the shape block-RAM inference expects.
module mmio_mem_ram #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 32,
    localparam int unsigned BE_W  = DATA_W / 8,
    localparam int unsigned DEPTH = 2 ** ADDR_W
) (
    input  logic              clk,
    input  logic              rd_en_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic [DATA_W-1:0] rd_data_o,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic [BE_W-1:0]   be_i
);

    // NOTE: the array has no reset port; a reset would block RAM inference.
    // The declaration initialiser gives all-zero contents at configuration.
    logic [DATA_W-1:0] mem_q [DEPTH] = '{default: '0};
    logic [DATA_W-1:0] rd_data_q;

    // NOTE: non-blocking writes make the read see pre-edge contents (read-first).
    always_ff @(posedge clk) begin
        if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end
        for (int b = 0; b < BE_W; b++) begin
            if (wr_en_i && be_i[b]) begin
                mem_q[wr_addr_i][b*8 +: 8] <= wr_data_i[b*8 +: 8];
            end
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/mmio_mem.sv
// Memory-mapped RAM with four I/O registers (LED, switches, cycle counter,
// scratch) in the top four word addresses; one-cycle synchronous reads.
module mmio_mem
    import mmio_pkg::*;
#(
    parameter int unsigned       ADDR_W   = 8,
    parameter int unsigned       DATA_W   = 32,
    parameter int unsigned       LED_W    = 5,
    parameter logic [LED_W-1:0]  LED_INIT = 5'h1F,
    parameter int unsigned       SW_W     = 4
) (
    input  logic             clk,
    input  logic             reset,
    mmio_mem_if.slave        bus,
    input  logic [SW_W-1:0]  sw,
    output logic [LED_W-1:0] led
);

    localparam int unsigned BE_W = DATA_W / 8;

    io_sel_e           rd_sel;
    io_sel_e           wr_sel;
    io_sel_e           rd_sel_q;
    logic              rd_valid_q;
    logic              ram_rd_en;
    logic              ram_wr_en;
    logic [DATA_W-1:0] ram_rdata;
    logic [DATA_W-1:0] io_rdata_q, io_rdata_d;
    logic [DATA_W-1:0] led_q, led_d;
    logic [DATA_W-1:0] scr_q, scr_d;
    logic [DATA_W-1:0] cyc_q, cyc_d;
    logic [SW_W-1:0]   sw_meta_q, sw_sync_q;

    function automatic logic [DATA_W-1:0] merge_bytes(
        input logic [DATA_W-1:0] old_v,
        input logic [DATA_W-1:0] new_v,
        input logic [BE_W-1:0]   be
    );
        logic [DATA_W-1:0] res;
        res = old_v;
        for (int b = 0; b < BE_W; b++) begin
            if (be[b]) res[b*8 +: 8] = new_v[b*8 +: 8];
        end
        return res;
    endfunction

    assign rd_sel = decode_sel(&bus.read_address[ADDR_W-1:IO_BITS],
                               ~bus.read_address[IO_BITS-1:0]);
    assign wr_sel = decode_sel(&bus.write_address[ADDR_W-1:IO_BITS],
                               ~bus.write_address[IO_BITS-1:0]);

    assign ram_rd_en = bus.rd_en && (rd_sel == SEL_RAM);
    assign ram_wr_en = bus.write_enable && (wr_sel == SEL_RAM);

    mmio_mem_ram #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_ram (
        .clk       (clk),
        .rd_en_i   (ram_rd_en),
        .rd_addr_i (bus.read_address),
        .rd_data_o (ram_rdata),
        .wr_en_i   (ram_wr_en),
        .wr_addr_i (bus.write_address),
        .wr_data_i (bus.write_data),
        .be_i      (bus.byte_en)
    );

    // NOTE: every variable gets a default first so no latch is inferred.
    always_comb begin
        led_d      = led_q;
        scr_d      = scr_q;
        cyc_d      = cyc_q + DATA_W'(1);
        io_rdata_d = io_rdata_q;

        // A masked counter write replaces that cycle's increment; SW is read-only.
        if (bus.write_enable && (|bus.byte_en)) begin
            case (wr_sel)
                SEL_LED: led_d = merge_bytes(led_q, bus.write_data, bus.byte_en);
                SEL_SCR: scr_d = merge_bytes(scr_q, bus.write_data, bus.byte_en);
                SEL_CYC: cyc_d = merge_bytes(cyc_q, bus.write_data, bus.byte_en);
                default: ;
            endcase
        end

        if (bus.rd_en) begin
            case (rd_sel)
                SEL_LED: io_rdata_d = led_q;
                SEL_SW:  io_rdata_d = DATA_W'(sw_sync_q);
                SEL_CYC: io_rdata_d = cyc_q;
                SEL_SCR: io_rdata_d = scr_q;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_valid_q <= 1'b0;
            rd_sel_q   <= SEL_LED;
            io_rdata_q <= '0;
            led_q      <= DATA_W'(LED_INIT);
            scr_q      <= '0;
            cyc_q      <= '0;
            sw_meta_q  <= '0;
            sw_sync_q  <= '0;
        end else begin
            rd_valid_q <= bus.rd_en;
            if (bus.rd_en) rd_sel_q <= rd_sel;
            io_rdata_q <= io_rdata_d;
            led_q      <= led_d;
            scr_q      <= scr_d;
            cyc_q      <= cyc_d;
            sw_meta_q  <= sw;
            sw_sync_q  <= sw_meta_q;
        end
    end

    // rd_sel_q only moves on a read, so rd_data holds between reads.
    assign bus.rd_data  = (rd_sel_q == SEL_RAM) ? ram_rdata : io_rdata_q;
    assign bus.rd_valid = rd_valid_q;
    assign led          = led_q[LED_W-1:0];

endmodule

// File: tb/tb_mmio_mem.sv
// Directed self-checking bench for mmio_mem: reset state, RAM byte masks,
// read-first behaviour, I/O registers, switch synchroniser and reset-during-read.
module tb_mmio_mem;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] sw;
    logic [4:0] led;

    int unsigned n_pass  = 0;
    int unsigned n_total = 0;

    mmio_mem_if #(.ADDR_W(8), .DATA_W(32)) bus ();

    mmio_mem #(
        .ADDR_W   (8),
        .DATA_W   (32),
        .LED_W    (5),
        .LED_INIT (5'h1F),
        .SW_W     (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .sw    (sw),
        .led   (led)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic rd, input logic [7:0] ra, input logic we,
                         input logic [7:0] wa, input logic [31:0] wd, input logic [3:0] be);
        bus.rd_en         = rd;
        bus.read_address  = ra;
        bus.write_enable  = we;
        bus.write_address = wa;
        bus.write_data    = wd;
        bus.byte_en       = be;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    initial begin
        reset = 1'b1;
        sw    = 4'b0000;
        drive(1'b0, 8'h00, 1'b0, 8'h00, 32'h0, 4'h0);
        tick();
        tick();
        check("rst_rd_valid", 32'(bus.rd_valid), 32'h0);
        check("rst_rd_data", bus.rd_data, 32'h0);
        check("rst_led", 32'(led), 32'h1F);

        // Counter reads 0 on the first edge after release, then counts.
        reset = 1'b0;
        drive(1'b1, 8'hFD, 1'b0, 8'h00, 32'h0, 4'h0);
        tick();
        check("cyc_first", bus.rd_data, 32'h0);
        check("cyc_first_valid", 32'(bus.rd_valid), 32'h1);
        tick();
        check("cyc_second", bus.rd_data, 32'h1);

        drive(1'b1, 8'hFF, 1'b0, 8'h00, 32'h0, 4'h0);
        tick();
        check("led_reg_read", bus.rd_data, 32'h0000001F);
        check("led_reg_valid", 32'(bus.rd_valid), 32'h1);
        check("led_out", 32'(led), 32'h1F);
        drive(1'b0, 8'h00, 1'b0, 8'h00, 32'h0, 4'h0);
        tick();
        check("valid_drop", 32'(bus.rd_valid), 32'h0);
        check("rd_data_hold", bus.rd_data, 32'h0000001F);

        // RAM: zero at configuration, byte mask, be=0 no-op.
        drive(1'b1, 8'h10, 1'b0, 8'h00, 32'h0, 4'h0);
        tick();
        check("ram_init_zero", bus.rd_data, 32'h0);
        drive(1'b0, 8'h00, 1'b1, 8'h10, 32'hAABBCCDD, 4'b0101);
        tick();
        drive(1'b0, 8'h00, 1'b1, 8'h10, 32'hFFFFFFFF, 4'b0000);
        tick();
        drive(1'b1, 8'h10, 1'b0, 8'h00, 32'h0, 4'h0);
        tick();
        check("ram_byte_mask", bus.rd_data, 32'h00BB00DD);

        // RAM read-first on a same-address read/write.
        drive(1'b0, 8'h00, 1'b1, 8'h20, 32'h11111111, 4'hF);
        tick();
        drive(1'b1, 8'h20, 1'b1, 8'h20, 32'h22222222, 4'hF);
        tick();
        check("ram_read_first", bus.rd_data, 32'h11111111);
        drive(1'b1, 8'h20, 1'b0, 8'h00, 32'h0, 4'h0);
        tick();
        check("ram_after_write", bus.rd_data, 32'h22222222);

        // Counter load and wrap.
        drive(1'b0, 8'h00, 1'b1, 8'hFD, 32'hFFFFFFFE, 4'hF);
        tick();
        drive(1'b1, 8'hFD, 1'b0, 8'h00, 32'h0, 4'h0);
        tick();
        check("cyc_loaded", bus.rd_data, 32'hFFFFFFFE);
        tick();
        check("cyc_all_ones", bus.rd_data, 32'hFFFFFFFF);
        tick();
        check("cyc_wrap", bus.rd_data, 32'h00000000);

        // LED byte write and I/O read-first.
        drive(1'b0, 8'h00, 1'b1, 8'hFF, 32'h000000AA, 4'b0001);
        tick();
        check("led_after_write", 32'(led), 32'h0A);
        drive(1'b1, 8'hFF, 1'b1, 8'hFF, 32'h00000003, 4'b0001);
        tick();
        check("led_read_first", bus.rd_data, 32'h000000AA);
        check("led_new_value", 32'(led), 32'h03);

        // Scratch byte-masked write.
        drive(1'b0, 8'h00, 1'b1, 8'hFC, 32'h12345678, 4'b1100);
        tick();
        drive(1'b1, 8'hFC, 1'b0, 8'h00, 32'h0, 4'h0);
        tick();
        check("scratch_mask", bus.rd_data, 32'h12340000);

        // Switch synchroniser: two-flop delay, writes ignored.
        sw = 4'b1010;
        drive(1'b1, 8'hFE, 1'b0, 8'h00, 32'h0, 4'h0);
        tick();
        check("sw_old", bus.rd_data, 32'h0);
        drive(1'b0, 8'h00, 1'b0, 8'h00, 32'h0, 4'h0);
        tick();
        drive(1'b1, 8'hFE, 1'b0, 8'h00, 32'h0, 4'h0);
        tick();
        check("sw_synced", bus.rd_data, 32'h0000000A);
        drive(1'b0, 8'h00, 1'b1, 8'hFE, 32'hFFFFFFFF, 4'hF);
        tick();
        drive(1'b1, 8'hFE, 1'b0, 8'h00, 32'h0, 4'h0);
        tick();
        check("sw_write_ignored", bus.rd_data, 32'h0000000A);

        // Read issued with reset: dropped, registers reinitialised, RAM kept.
        drive(1'b1, 8'h10, 1'b0, 8'h00, 32'h0, 4'h0);
        reset = 1'b1;
        #1;
        check("async_rst_valid", 32'(bus.rd_valid), 32'h0);
        check("async_rst_data", bus.rd_data, 32'h0);
        tick();
        drive(1'b0, 8'h00, 1'b0, 8'h00, 32'h0, 4'h0);
        reset = 1'b0;
        tick();
        check("no_pulse_1", 32'(bus.rd_valid), 32'h0);
        tick();
        check("no_pulse_2", 32'(bus.rd_valid), 32'h0);
        drive(1'b1, 8'hFF, 1'b0, 8'h00, 32'h0, 4'h0);
        tick();
        check("led_after_reset", bus.rd_data, 32'h0000001F);
        drive(1'b1, 8'hFC, 1'b0, 8'h00, 32'h0, 4'h0);
        tick();
        check("scratch_after_reset", bus.rd_data, 32'h0);
        drive(1'b1, 8'h10, 1'b0, 8'h00, 32'h0, 4'h0);
        tick();
        check("ram_kept", bus.rd_data, 32'h00BB00DD);
        drive(1'b0, 8'h00, 1'b0, 8'h00, 32'h0, 4'h0);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mmio_mem.md
MMIO_MEM -- requirements
Module: mmio_mem

Interface
REQ-001 Parameter ADDR_W, default 8, SHALL set word-address width; depth = 2**ADDR_W words.
REQ-002 Parameter DATA_W, default 32, SHALL set word width; it SHALL be a multiple of 8, and BE_W = DATA_W/8.
REQ-003 Parameter LED_W, default 5, SHALL set LED output width; it SHALL be no more than DATA_W.
REQ-004 Parameter LED_INIT, default 5'h1F, SHALL set the LED register reset value.
REQ-005 Parameter SW_W, default 4, SHALL set switch input width; it SHALL be no more than DATA_W.
REQ-006 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-007 reset  input  1  asynchronous, active-high reset.
REQ-008 rd_en  input  1  read request.
REQ-009 read_address  input  ADDR_W  read word address.
REQ-010 rd_data  output  DATA_W  read result.
REQ-011 rd_valid  output  1  high for exactly one cycle when rd_data holds a result.
REQ-012 write_enable  input  1  write request.
REQ-013 write_address  input  ADDR_W  write word address.
REQ-014 write_data  input  DATA_W  write data.
REQ-015 byte_en  input  BE_W  per-byte write mask.
REQ-016 sw  input  SW_W  asynchronous switch inputs.
REQ-017 led  output  LED_W  LED drive.

Function
REQ-018 The top four addresses SHALL be the I/O region: all-ones = LED_REG, all-ones-1 = SW_REG, all-ones-2 = CYC_REG, all-ones-3 = SCRATCH; every lower address SHALL be RAM.
REQ-019 Reads SHALL be synchronous: rd_en at edge N SHALL give rd_data and rd_valid=1 after edge N+1.
REQ-020 rd_data SHALL hold its last value while rd_valid=0.
REQ-021 A write to a RAM address SHALL update only the bytes whose byte_en bit is 1; byte_en=0 SHALL make the write a no-op.
REQ-022 A read and a write to the same address in one cycle SHALL return the old data (read-first); this SHALL apply to RAM and I/O alike.
REQ-023 LED_REG SHALL be a DATA_W register with byte-masked writes; led SHALL equal its bits [LED_W-1:0].
REQ-024 sw SHALL pass through a 2-flop synchroniser; SW_REG reads SHALL return the synchronised value zero-extended to DATA_W.
REQ-025 Writes to SW_REG SHALL be ignored.
REQ-026 CYC_REG SHALL increment by 1 every cycle and wrap from all-ones to 0.
REQ-027 A write to CYC_REG with any byte_en bit set SHALL apply the masked write_data; the increment SHALL NOT apply that cycle, and counting SHALL resume from the written value on the next cycle.
REQ-028 A CYC_REG read SHALL return the value before the edge that samples rd_en.
REQ-029 SCRATCH SHALL be a plain DATA_W read/write register with byte-masked writes.
REQ-030 Address inputs SHALL be full width, so out-of-range access is impossible; no error signalling SHALL exist.

Reset
REQ-031 While reset=1: rd_valid=0, rd_data=0, LED_REG=LED_INIT zero-extended, SCRATCH=0, CYC_REG=0, synchroniser flops=0.
REQ-032 RAM contents SHALL NOT be reset; RAM SHALL initialise to all-zero at configuration.
REQ-033 A read issued in the cycle reset asserts SHALL be dropped, with no rd_valid pulse after reset releases.
REQ-034 A write in flight when reset asserts SHALL NOT be required to complete.
REQ-035 CYC_REG SHALL read 0 in the first cycle after reset release and then count.

Structure
REQ-036 A shared package mmio_pkg SHALL hold the I/O offsets (LED_OFS=0, SW_OFS=1, CYC_OFS=2, SCR_OFS=3, measured downward from all-ones) and the I/O region size of 4.
REQ-037 One sub-module, mmio_mem_ram, SHALL implement the byte-enabled synchronous read-first RAM so that it infers block RAM.
REQ-038 The top level SHALL hold the address decode, I/O registers, synchroniser, counter and output mux.

Verification
REQ-039 Reset, then read 8'hFF -> rd_valid 1 cycle later, rd_data=32'h0000001F, led=5'h1F.
REQ-040 Write 8'h10 with 32'hAABBCCDD and byte_en=4'b0101 over a zero word, then read 8'h10 -> 32'h00BB00DD.
REQ-041 Write 8'h20 with 32'h11111111, then in one cycle read 8'h20 and write 8'h20 with 32'h22222222 -> read returns 32'h11111111; the next read returns 32'h22222222.
REQ-042 Write CYC_REG (8'hFD) with 32'hFFFFFFFE, then read on the two following cycles -> 32'hFFFFFFFE, then 32'hFFFFFFFF; a read one cycle later -> 32'h00000000 (wrap).
REQ-043 Set sw=4'b1010, then read 8'hFE within 1 cycle -> old value; read after 3 cycles -> 32'h0000000A; writing 8'hFE has no effect.
REQ-044 Assert rd_en and reset in the same cycle -> no rd_valid pulse, and LED_REG reads 32'h1F after release.
